// File: rtl/servant_uart_rx_if.sv
// Wishbone slave bundle for the servant UART receiver.
// cyc doubles as strobe; adr selects DATA (0) or STATUS (1).
interface servant_uart_rx_if;
    logic        i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a one-byte holding register,
// overrun/framing flags and a minimal Wishbone slave port.
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              i_rx,
    servant_uart_rx_if.slave  wb
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);

    logic        rx_meta;
    logic        rxs;
    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_n;
    logic [7:0]  shreg;
    logic [7:0]  sh_n;
    logic        expired;
    logic        byte_done;
    logic        frame_set;

    logic [7:0]  rx_data;
    logic        valid;
    logic        overrun;
    logic        frame_err;
    logic        ack;
    logic [31:0] rdt;
    logic        wb_req;
    logic        data_rd;
    logic        stat_wr;
    logic        unused_dat;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    // Count down to 1 so a reload of N gives exactly N cycles per bit
    assign expired = (cnt == 16'd1);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        sh_n      = shreg;
        byte_done = 1'b0;
        frame_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = HALF;
                end
            end
            START: begin
                if (!expired) begin
                    cnt_n = cnt - 16'd1;
                end else if (!rxs) begin
                    state_n = DATA;
                    cnt_n   = FULL;
                    bit_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    sh_n  = {rxs, shreg[7:1]};
                    cnt_n = FULL;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (!expired) begin
                    cnt_n = cnt - 16'd1;
                end else if (rxs) begin
                    state_n   = IDLE;
                    byte_done = 1'b1;
                end else begin
                    state_n   = WAIT_HIGH;
                    frame_set = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Side effects happen only on the edge that raises ack
    assign wb_req  = wb.i_wb_cyc & ~ack;
    assign data_rd = wb_req & ~wb.i_wb_we & ~wb.i_wb_adr;
    assign stat_wr = wb_req & wb.i_wb_we & wb.i_wb_adr;

    assign unused_dat = ^{wb.i_wb_dat[31:3], wb.i_wb_dat[0]};

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            rx_data   <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            ack       <= 1'b0;
            rdt       <= '0;
        end else begin
            ack <= wb.i_wb_cyc & ~ack;
            if (wb_req && !wb.i_wb_we) begin
                if (wb.i_wb_adr)
                    rdt <= {29'b0, frame_err, overrun, valid};
                else
                    rdt <= {23'b0, valid, rx_data};
            end
            if (byte_done && (!valid || data_rd)) begin
                rx_data <= shreg;
                valid   <= 1'b1;
            end else if (data_rd) begin
                valid <= 1'b0;
            end
            if (byte_done && valid && !data_rd)
                overrun <= 1'b1;
            else if (stat_wr && wb.i_wb_dat[1])
                overrun <= 1'b0;
            if (frame_set)
                frame_err <= 1'b1;
            else if (stat_wr && wb.i_wb_dat[2])
                frame_err <= 1'b0;
        end
    end

    assign wb.o_wb_ack = ack;
    assign wb.o_wb_rdt = rdt;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx at 16 clocks per bit,
// with a byte scoreboard and a flag model.
module tb_servant_uart_rx;

    localparam int CPB = 16;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;
    logic i_rx   = 1'b1;

    servant_uart_rx_if wb();

    servant_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .i_rx   (i_rx),
        .wb     (wb)
    );

    always #5 wb_clk = ~wb_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic        m_ferr  = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Call at #1 after a rising edge
    task automatic wb_xfer(input logic adr, input logic we,
                           input logic [31:0] dat,
                           output logic [31:0] d);
        int n;
        n = 0;
        wb.i_wb_adr = adr;
        wb.i_wb_we  = we;
        wb.i_wb_dat = dat;
        wb.i_wb_cyc = 1'b1;
        do begin
            @(posedge wb_clk);
            #1;
            n++;
        end while (!wb.o_wb_ack && n < 4);
        d = wb.o_wb_rdt;
        check("wb_ack", {31'b0, wb.o_wb_ack}, 32'd1);
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_we  = 1'b0;
    endtask

    task automatic rd_status(input string tag);
        logic [31:0] d;
        wb_xfer(1'b1, 1'b0, 32'd0, d);
        check(tag, d, {29'b0, m_ferr, m_ovr, m_valid});
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead;
        wb_xfer(1'b0, 1'b0, 32'd0, d);
        m_valid = 1'b0;
        check(tag, d, e);
    endtask

    task automatic wr_status(input logic [31:0] v);
        logic [31:0] d;
        wb_xfer(1'b1, 1'b1, v, d);
        if (v[1]) m_ovr  = 1'b0;
        if (v[2]) m_ferr = 1'b0;
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (!m_valid) begin
            exp_q.push_back({23'b0, 1'b1, b});
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // Start bit plus 8 data bits; returns on the edge where stop begins
    task automatic send_head(input logic [7:0] b);
        @(posedge wb_clk);
        #1 i_rx = 1'b0;
        repeat (CPB) @(posedge wb_clk);
        for (int i = 0; i < 8; i++) begin
            #1 i_rx = b[i];
            repeat (CPB) @(posedge wb_clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        #1 i_rx = 1'b1;
        repeat (CPB + 4) @(posedge wb_clk);
        #1;
        model_rx(b);
    endtask

    initial begin
        logic [31:0] d;
        int acks;
        wb.i_wb_adr = 1'b0;
        wb.i_wb_dat = '0;
        wb.i_wb_we  = 1'b0;
        wb.i_wb_cyc = 1'b0;

        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
        check("rst_rdt", wb.o_wb_rdt, 32'd0);
        wb_rst = 1'b0;
        repeat (2) @(posedge wb_clk);
        #1;
        rd_status("rst_status");

        // 0xA5: valid visible right after the stop sample
        send_head(8'hA5);
        #1 i_rx = 1'b1;
        repeat (11) @(posedge wb_clk);
        #1;
        model_rx(8'hA5);
        wb_xfer(1'b1, 1'b0, 32'd0, d);
        check("a5_valid_timing", d, 32'h1);
        repeat (8) @(posedge wb_clk);
        #1;
        rd_data("a5_data");
        rd_status("a5_status");
        wb_xfer(1'b0, 1'b1, 32'hFFFF_FFFF, d);
        rd_status("data_wr_ignored");

        // ack toggles while cyc is held
        wb.i_wb_adr = 1'b1;
        wb.i_wb_we  = 1'b0;
        wb.i_wb_cyc = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge wb_clk);
            #1;
            if (wb.o_wb_ack) acks++;
        end
        wb.i_wb_cyc = 1'b0;
        check("ack_alternate", 32'(acks), 32'd3);
        repeat (2) @(posedge wb_clk);
        #1;

        // overrun
        send_byte(8'h3C);
        send_byte(8'h7E);
        rd_status("ovr_status");
        rd_data("ovr_data");
        rd_status("ovr_after_read");
        wr_status(32'h2);
        rd_status("ovr_cleared");

        // framing error, line held low 40 cycles
        send_head(8'h55);
        #1 i_rx = 1'b0;
        repeat (40) @(posedge wb_clk);
        #1 i_rx = 1'b1;
        m_ferr = 1'b1;
        repeat (4) @(posedge wb_clk);
        #1;
        rd_status("ferr_status");
        wr_status(32'h4);
        rd_status("ferr_cleared");
        send_byte(8'h81);
        rd_data("after_ferr_data");
        rd_status("after_ferr_status");

        // 5-cycle glitch is rejected
        @(posedge wb_clk);
        #1 i_rx = 1'b0;
        repeat (5) @(posedge wb_clk);
        #1 i_rx = 1'b1;
        repeat (30) @(posedge wb_clk);
        #1;
        rd_status("glitch_status");
        send_byte(8'hC3);
        rd_data("glitch_next_data");

        // reset mid-frame at bit 4
        @(posedge wb_clk);
        #1 i_rx = 1'b0;
        repeat (CPB) @(posedge wb_clk);
        for (int i = 0; i < 4; i++) begin
            #1 i_rx = i[0];
            repeat (CPB) @(posedge wb_clk);
        end
        #1 wb_rst = 1'b1;
        i_rx = 1'b1;
        repeat (3) @(posedge wb_clk);
        #1;
        check("midrst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
        check("midrst_rdt", wb.o_wb_rdt, 32'd0);
        wb_rst = 1'b0;
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        repeat (CPB * 12) @(posedge wb_clk);
        #1;
        rd_status("midrst_status");
        send_byte(8'h42);
        rd_status("midrst_0x42_status");
        rd_data("midrst_0x42_data");

        // DATA read ack lands on the second byte's completion edge
        send_byte(8'h24);
        send_head(8'h99);
        #1 i_rx = 1'b1;
        repeat (10) @(posedge wb_clk);
        #1;
        rd_data("race_first_data");
        model_rx(8'h99);
        repeat (8) @(posedge wb_clk);
        #1;
        rd_status("race_status");
        rd_data("race_second_data");
        rd_status("race_final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
